// File: rtl/mac_layer_sched.sv
// Fully-connected layer sequencer: walks NEURONS dot products of WIDTH terms through
// an external MAC core and synchronous memories, reporting each result and the signed argmax.
module mac_layer_sched #(
    parameter int BITS    = 24,
    parameter int WIDTH   = 784,
    parameter int NEURONS = 10,
    parameter int MEM_LAT = 1,
    parameter int PA_W    = $clog2(WIDTH),
    parameter int WA_W    = $clog2(WIDTH * NEURONS),
    parameter int NI_W    = $clog2(NEURONS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [PA_W-1:0] pix_addr,
    output logic [WA_W-1:0] wgt_addr,
    output logic            mac_en,
    output logic            mac_clr,
    input  logic [BITS-1:0] mac_out,
    output logic            res_valid,
    output logic [NI_W-1:0] res_idx,
    output logic [BITS-1:0] res_data,
    output logic [NI_W-1:0] class_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_DRAIN,
        S_STORE,
        S_DONE
    } state_t;

    localparam logic [PA_W-1:0] PIX_LAST   = PA_W'(WIDTH - 1);
    localparam logic [NI_W-1:0] NEUR_LAST  = NI_W'(NEURONS - 1);
    localparam logic [2:0]      DRAIN_LAST = 3'(MEM_LAT - 1);

    state_t               state_q, state_d;
    logic [PA_W-1:0]      pix_addr_q, pix_addr_d;
    logic [WA_W-1:0]      wgt_addr_q, wgt_addr_d;
    logic [NI_W-1:0]      neuron_q, neuron_d;
    logic [2:0]           drain_cnt_q, drain_cnt_d;
    logic [BITS-1:0]      best_q, best_d;
    logic [NI_W-1:0]      best_idx_q, best_idx_d;
    logic                 res_valid_q, res_valid_d;
    logic [NI_W-1:0]      res_idx_q, res_idx_d;
    logic [BITS-1:0]      res_data_q, res_data_d;
    logic [NI_W-1:0]      class_out_q, class_out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [MEM_LAT-1:0]   en_pipe_q, en_pipe_d;

    always_comb begin
        state_d     = state_q;
        pix_addr_d  = pix_addr_q;
        wgt_addr_d  = wgt_addr_q;
        neuron_d    = neuron_q;
        drain_cnt_d = drain_cnt_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        res_valid_d = 1'b0;
        res_idx_d   = res_idx_q;
        res_data_d  = res_data_q;
        class_out_d = class_out_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_CLEAR;
                    neuron_d   = '0;
                    wgt_addr_d = '0;
                end
            end
            S_CLEAR: begin
                pix_addr_d = '0;
                state_d    = S_LOAD;
            end
            S_LOAD: begin
                // Weight address runs on across neurons, so no neuron*WIDTH product is needed.
                pix_addr_d = pix_addr_q + PA_W'(1);
                wgt_addr_d = wgt_addr_q + WA_W'(1);
                if (pix_addr_q == PIX_LAST) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = S_STORE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 3'd1;
                end
            end
            S_STORE: begin
                // Result registers are loaded here and therefore strobe out one cycle later.
                res_valid_d = 1'b1;
                res_data_d  = mac_out;
                res_idx_d   = neuron_q;
                if (neuron_q == '0 || $signed(mac_out) > $signed(best_q)) begin
                    best_d     = mac_out;
                    best_idx_d = neuron_q;
                end
                if (neuron_q == NEUR_LAST) begin
                    state_d = S_DONE;
                end else begin
                    neuron_d = neuron_q + NI_W'(1);
                    state_d  = S_CLEAR;
                end
            end
            S_DONE: begin
                class_out_d = best_idx_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);

        en_pipe_d[0] = (state_q == S_LOAD);
        for (int i = 1; i < MEM_LAT; i++) begin
            en_pipe_d[i] = en_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pix_addr_q  <= '0;
            wgt_addr_q  <= '0;
            neuron_q    <= '0;
            drain_cnt_q <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
            res_data_q  <= '0;
            class_out_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            en_pipe_q   <= '0;
        end else begin
            state_q     <= state_d;
            pix_addr_q  <= pix_addr_d;
            wgt_addr_q  <= wgt_addr_d;
            neuron_q    <= neuron_d;
            drain_cnt_q <= drain_cnt_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            res_valid_q <= res_valid_d;
            res_idx_q   <= res_idx_d;
            res_data_q  <= res_data_d;
            class_out_q <= class_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            en_pipe_q   <= en_pipe_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pix_addr  = pix_addr_q;
    assign wgt_addr  = wgt_addr_q;
    assign mac_en    = en_pipe_q[MEM_LAT-1];
    assign mac_clr   = reset | (state_q == S_CLEAR);
    assign res_valid = res_valid_q;
    assign res_idx   = res_idx_q;
    assign res_data  = res_data_q;
    assign class_out = class_out_q;

endmodule

// File: tb/tb_mac_layer_sched.sv
// Bench for mac_layer_sched: three instances (small/lat1, small/lat3, full size) each with
// behavioural memories and MAC; results checked against a queue-based scoreboard.
module tb_mac_layer_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        a_start, a_busy, a_done, a_mac_en, a_mac_clr, a_res_valid;
    logic [1:0]  a_pix_addr, a_res_idx, a_class_out;
    logic [3:0]  a_wgt_addr;
    logic [23:0] a_mac_out, a_res_data, a_pd, a_wd;

    logic        b_start, b_busy, b_done, b_mac_en, b_mac_clr, b_res_valid;
    logic [1:0]  b_pix_addr, b_res_idx, b_class_out;
    logic [3:0]  b_wgt_addr;
    logic [23:0] b_mac_out, b_res_data;
    logic [23:0] b_pd [3];
    logic [23:0] b_wd [3];

    logic        c_start, c_busy, c_done, c_mac_en, c_mac_clr, c_res_valid;
    logic [9:0]  c_pix_addr;
    logic [12:0] c_wgt_addr;
    logic [3:0]  c_res_idx, c_class_out;
    logic [23:0] c_mac_out, c_res_data, c_pd, c_wd;

    logic [23:0] pix_mem [0:783];
    logic [23:0] wgt_mem [0:7839];

    mac_layer_sched #(.WIDTH(4), .NEURONS(3), .MEM_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .busy(a_busy), .done(a_done),
        .pix_addr(a_pix_addr), .wgt_addr(a_wgt_addr), .mac_en(a_mac_en), .mac_clr(a_mac_clr),
        .mac_out(a_mac_out), .res_valid(a_res_valid), .res_idx(a_res_idx),
        .res_data(a_res_data), .class_out(a_class_out));

    mac_layer_sched #(.WIDTH(4), .NEURONS(3), .MEM_LAT(3)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .busy(b_busy), .done(b_done),
        .pix_addr(b_pix_addr), .wgt_addr(b_wgt_addr), .mac_en(b_mac_en), .mac_clr(b_mac_clr),
        .mac_out(b_mac_out), .res_valid(b_res_valid), .res_idx(b_res_idx),
        .res_data(b_res_data), .class_out(b_class_out));

    mac_layer_sched dut_c (
        .clk(clk), .reset(reset), .start(c_start), .busy(c_busy), .done(c_done),
        .pix_addr(c_pix_addr), .wgt_addr(c_wgt_addr), .mac_en(c_mac_en), .mac_clr(c_mac_clr),
        .mac_out(c_mac_out), .res_valid(c_res_valid), .res_idx(c_res_idx),
        .res_data(c_res_data), .class_out(c_class_out));

    // Memories with registered read (latency 1 for a/c, 3 for b) and a wrapping 24-bit MAC.
    always @(posedge clk) begin
        a_pd    <= pix_mem[a_pix_addr];
        a_wd    <= wgt_mem[a_wgt_addr];
        c_pd    <= pix_mem[c_pix_addr];
        c_wd    <= wgt_mem[c_wgt_addr];
        b_pd[0] <= pix_mem[b_pix_addr];
        b_wd[0] <= wgt_mem[b_wgt_addr];
        b_pd[1] <= b_pd[0];
        b_wd[1] <= b_wd[0];
        b_pd[2] <= b_pd[1];
        b_wd[2] <= b_wd[1];
        if (a_mac_clr) a_mac_out <= '0;
        else if (a_mac_en) a_mac_out <= a_mac_out + a_pd * a_wd;
        if (b_mac_clr) b_mac_out <= '0;
        else if (b_mac_en) b_mac_out <= b_mac_out + b_pd[2] * b_wd[2];
        if (c_mac_clr) c_mac_out <= '0;
        else if (c_mac_en) c_mac_out <= c_mac_out + c_pd * c_wd;
    end

    int sel;
    int s_busy, s_done, s_en, s_clr, s_rv, s_pix, s_wgt, s_ridx, s_cls;
    logic [23:0] s_rdata;

    always_comb begin
        s_busy = 0; s_done = 0; s_en = 0; s_clr = 0; s_rv = 0;
        s_pix = 0; s_wgt = 0; s_ridx = 0; s_cls = 0; s_rdata = '0;
        case (sel)
            0: begin
                s_busy = int'(a_busy); s_done = int'(a_done); s_en = int'(a_mac_en);
                s_clr = int'(a_mac_clr); s_rv = int'(a_res_valid); s_pix = int'(a_pix_addr);
                s_wgt = int'(a_wgt_addr); s_ridx = int'(a_res_idx); s_cls = int'(a_class_out);
                s_rdata = a_res_data;
            end
            1: begin
                s_busy = int'(b_busy); s_done = int'(b_done); s_en = int'(b_mac_en);
                s_clr = int'(b_mac_clr); s_rv = int'(b_res_valid); s_pix = int'(b_pix_addr);
                s_wgt = int'(b_wgt_addr); s_ridx = int'(b_res_idx); s_cls = int'(b_class_out);
                s_rdata = b_res_data;
            end
            default: begin
                s_busy = int'(c_busy); s_done = int'(c_done); s_en = int'(c_mac_en);
                s_clr = int'(c_mac_clr); s_rv = int'(c_res_valid); s_pix = int'(c_pix_addr);
                s_wgt = int'(c_wgt_addr); s_ridx = int'(c_res_idx); s_cls = int'(c_class_out);
                s_rdata = c_res_data;
            end
        endcase
    end

    int vectors = 0;
    int miscompares = 0;
    logic [23:0] exp_data_q [$];
    int          exp_idx_q  [$];
    int hist_p [0:9199];
    int hist_w [0:9199];

    task automatic drive_start(input int s, input logic v);
        case (s)
            0: a_start = v;
            1: b_start = v;
            default: c_start = v;
        endcase
    endtask

    // Reference dot products with 24-bit wrap; argmax keeps the lowest index on ties.
    task automatic push_expected(input int w, input int n, output int cls);
        logic [23:0] acc, best;
        exp_data_q.delete();
        exp_idx_q.delete();
        best = '0;
        cls = 0;
        for (int j = 0; j < n; j++) begin
            acc = '0;
            for (int i = 0; i < w; i++) acc = acc + pix_mem[i] * wgt_mem[j*w+i];
            exp_data_q.push_back(acc);
            exp_idx_q.push_back(j);
            if (j == 0 || $signed(acc) > $signed(best)) begin
                best = acc;
                cls = j;
            end
        end
    endtask

    task automatic load_small(input logic [23:0] n2_w0, input logic [23:0] n2_w3);
        for (int i = 0; i < 4; i++) pix_mem[i] = 24'(i + 1);
        for (int i = 0; i < 4; i++) wgt_mem[i] = 24'd1;
        wgt_mem[4] = 24'd2; wgt_mem[5] = 24'd0; wgt_mem[6] = 24'd0; wgt_mem[7] = 24'd2;
        wgt_mem[8] = n2_w0; wgt_mem[9] = 24'd0; wgt_mem[10] = 24'd0; wgt_mem[11] = n2_w3;
    endtask

    // One full pass; expectations must already be in the scoreboard queue.
    task automatic run_pass(input int s, input int w, input int n, input int lat,
                            input int exp_cls, input bit harass);
        int exp_done, cyc, done_cyc, done_cnt, k, run;
        int busy_err, align_err, run_err, ovl_err;
        logic st;
        logic [23:0] ed;
        int ei;
        exp_done = n * (w + lat + 2) + 1;
        cyc = 0; done_cyc = -1; done_cnt = 0; k = 0; run = 0;
        busy_err = 0; align_err = 0; run_err = 0; ovl_err = 0;
        sel = s;
        @(negedge clk);
        drive_start(s, 1'b1);
        while (cyc < exp_done + 8 && cyc < 9000) begin
            @(negedge clk);
            cyc++;
            st = 1'b0;
            if (harass && cyc < exp_done && (cyc % 3) == 0) st = 1'b1;
            if (harass && s_done != 0) st = 1'b1;
            drive_start(s, st);
            hist_p[cyc] = s_pix;
            hist_w[cyc] = s_wgt;
            if (s_busy != ((cyc >= 1 && cyc <= exp_done) ? 1 : 0)) busy_err++;
            if (s_done != 0) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (s_en != 0 && s_clr != 0) ovl_err++;
            if (s_en != 0) begin
                if (cyc - lat < 1 || hist_w[cyc-lat] != k || hist_p[cyc-lat] != k % w) align_err++;
                k++;
                run++;
            end else begin
                if (run != 0 && run != w) run_err++;
                run = 0;
            end
            if (s_rv != 0) begin
                vectors++;
                if (exp_data_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL res_unexpected: got idx=%0d data=%0d, required no result", s_ridx, $signed(s_rdata));
                end else begin
                    ed = exp_data_q.pop_front();
                    ei = exp_idx_q.pop_front();
                    if (s_rdata !== ed || s_ridx != ei) begin
                        miscompares++;
                        $display("FAIL res_data: got idx=%0d data=%0d, required idx=%0d data=%0d",
                                 s_ridx, $signed(s_rdata), ei, $signed(ed));
                    end else begin
                        $display("result sel=%0d idx=%0d data=%0d", s, ei, $signed(ed));
                    end
                end
            end
        end
        drive_start(s, 1'b0);
        vectors += 9;
        if (done_cyc != exp_done) begin miscompares++; $display("FAIL done_cycle: got %0d, required %0d", done_cyc, exp_done); end
        if (done_cnt != 1) begin miscompares++; $display("FAIL done_count: got %0d, required 1", done_cnt); end
        if (k != w * n) begin miscompares++; $display("FAIL mac_en_total: got %0d, required %0d", k, w * n); end
        if (busy_err != 0) begin miscompares++; $display("FAIL busy_window: got %0d bad cycles, required 0", busy_err); end
        if (align_err != 0) begin miscompares++; $display("FAIL en_align_addr_seq: got %0d bad cycles, required 0", align_err); end
        if (run_err != 0) begin miscompares++; $display("FAIL en_run_length: got %0d bad runs, required 0", run_err); end
        if (ovl_err != 0) begin miscompares++; $display("FAIL clr_en_overlap: got %0d cycles, required 0", ovl_err); end
        if (exp_data_q.size() != 0) begin miscompares++; $display("FAIL res_missing: got %0d outstanding, required 0", exp_data_q.size()); end
        if (s_cls != exp_cls) begin miscompares++; $display("FAIL class_out: got %0d, required %0d", s_cls, exp_cls); end
        $display("pass sel=%0d done_cycle=%0d class_out=%0d", s, done_cyc, s_cls);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        sel = 0;
        repeat (3) @(negedge clk);
        vectors += 3;
        if (s_clr != 1) begin miscompares++; $display("FAIL reset_mac_clr: got %0d, required 1", s_clr); end
        if ({s_busy, s_done, s_en, s_rv, s_pix, s_wgt, s_ridx, s_cls} != 0 || s_rdata !== 24'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%0d done=%0d en=%0d rv=%0d pix=%0d wgt=%0d idx=%0d cls=%0d data=%0d, required all 0",
                     s_busy, s_done, s_en, s_rv, s_pix, s_wgt, s_ridx, s_cls, s_rdata);
        end
        reset = 1'b0;
        @(negedge clk);
        if (s_clr != 0 || s_busy != 0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got clr=%0d busy=%0d, required 0 0", s_clr, s_busy);
        end
        $display("reset checked");
    endtask

    task automatic test_tie();
        int cls;
        load_small(24'hFFFFFF, 24'd0);
        push_expected(4, 3, cls);
        run_pass(0, 4, 3, 1, 0, 1'b0);
    endtask

    task automatic test_argmax_last();
        int cls;
        load_small(24'd0, 24'd5);
        push_expected(4, 3, cls);
        run_pass(0, 4, 3, 1, 2, 1'b0);
    endtask

    task automatic test_mem_lat3();
        int cls;
        load_small(24'd0, 24'd5);
        push_expected(4, 3, cls);
        run_pass(1, 4, 3, 3, 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        int cls;
        load_small(24'd0, 24'd5);
        push_expected(4, 3, cls);
        run_pass(0, 4, 3, 1, 2, 1'b1);
        push_expected(4, 3, cls);
        run_pass(0, 4, 3, 1, 2, 1'b0);
    endtask

    task automatic test_reset_mid_pass();
        int cls, spurious;
        sel = 0;
        @(negedge clk);
        a_start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            a_start = 1'b0;
        end
        reset = 1'b1;
        #1;
        vectors += 3;
        if (s_clr != 1) begin miscompares++; $display("FAIL midreset_mac_clr: got %0d, required 1", s_clr); end
        @(negedge clk);
        if ({s_busy, s_done, s_en, s_rv, s_pix, s_wgt, s_ridx, s_cls} != 0 || s_rdata !== 24'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got busy=%0d done=%0d en=%0d rv=%0d pix=%0d wgt=%0d idx=%0d cls=%0d data=%0d, required all 0",
                     s_busy, s_done, s_en, s_rv, s_pix, s_wgt, s_ridx, s_cls, s_rdata);
        end
        reset = 1'b0;
        spurious = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (s_rv != 0 || s_done != 0 || s_busy != 0) spurious++;
        end
        if (spurious != 0) begin miscompares++; $display("FAIL midreset_quiet: got %0d active cycles, required 0", spurious); end
        $display("mid-pass reset checked");
        push_expected(4, 3, cls);
        run_pass(0, 4, 3, 1, 2, 1'b0);
    endtask

    task automatic test_defaults();
        int cls;
        for (int i = 0; i < 784; i++) pix_mem[i] = {16'd0, 8'($urandom)};
        for (int i = 0; i < 7840; i++) wgt_mem[i] = {16'd0, 8'($urandom)};
        push_expected(784, 10, cls);
        run_pass(2, 784, 10, 1, cls, 1'b0);
    endtask

    initial begin
        test_reset();
        test_tie();
        test_argmax_last();
        test_mem_lat3();
        test_back_to_back();
        test_reset_mid_pass();
        test_defaults();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
